// File: rtl/bru_pkg.sv
// Shared types for the branch execution unit: opcode encoding, request/response
// records at the default 32-bit datapath width, and small opcode helpers.
package bru_pkg;

    localparam int BRU_XLEN  = 32;
    localparam int BRU_TAG_W = 5;

    typedef enum logic [3:0] {
        BRU_BEQ  = 4'd0,
        BRU_BNE  = 4'd1,
        BRU_BLT  = 4'd2,
        BRU_BGE  = 4'd3,
        BRU_BLTU = 4'd4,
        BRU_BGEU = 4'd5,
        BRU_JAL  = 4'd6,
        BRU_JALR = 4'd7
    } bru_op_e;

    typedef struct packed {
        bru_op_e               op;
        logic [BRU_XLEN-1:0]   pc;
        logic [BRU_XLEN-1:0]   rs1;
        logic [BRU_XLEN-1:0]   rs2;
        logic [BRU_XLEN-1:0]   imm;
        logic                  pred_taken;
        logic [BRU_XLEN-1:0]   pred_target;
        logic [BRU_TAG_W-1:0]  tag;
    } bru_req_t;

    typedef struct packed {
        logic [BRU_TAG_W-1:0]  tag;
        logic                  taken;
        logic [BRU_XLEN-1:0]   next_pc;
        logic [BRU_XLEN-1:0]   link;
        logic                  mispredict;
        logic                  misalign;
    } bru_resp_t;

    function automatic logic is_jump(input logic [3:0] op);
        return (op == BRU_JAL) || (op == BRU_JALR);
    endfunction

    function automatic logic is_jalr(input logic [3:0] op);
        return op == BRU_JALR;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator; jumps and unknown opcodes yield 0.
module branch_cond_eval
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    bru_op_e                op_e;

    assign rs1_s = rs1;
    assign rs2_s = rs2;
    assign op_e  = bru_op_e'(op);

    always_comb begin
        cond = 1'b0;
        case (op_e)
            BRU_BEQ:  cond = (rs1 == rs2);
            BRU_BNE:  cond = (rs1 != rs2);
            BRU_BLT:  cond = (rs1_s <  rs2_s);
            BRU_BGE:  cond = (rs1_s >= rs2_s);
            BRU_BLTU: cond = (rs1 <  rs2);
            BRU_BGEU: cond = (rs1 >= rs2);
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_exec_unit.sv
// Two-stage branch/jump resolution unit with valid/ready on both sides and flush.
// Optional build macro BRU_PERF_CNT_EN adds resolved/mispredict counters.
module branch_exec_unit
    import bru_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter int ALIGN_LSB = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_misalign
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]      perf_resolved,
    output logic [31:0]      perf_mispredict
`endif
);

    logic            cond_p0;
    logic            taken_p0;
    logic [XLEN-1:0] target_p0;
    logic [XLEN-1:0] jalr_sum_p0;
    logic            in_fire;
    logic            out_fire;
    logic            s1_adv;
    logic            s2_adv;

    logic             vld_p1;
    logic             taken_p1;
    logic [XLEN-1:0]  target_p1;
    logic [XLEN-1:0]  pc_p1;
    logic             pred_taken_p1;
    logic [XLEN-1:0]  pred_target_p1;
    logic [TAG_W-1:0] tag_p1;

    logic [XLEN-1:0]  link_p1;
    logic [XLEN-1:0]  next_pc_p1;
    logic             mispredict_p1;
    logic             misalign_p1;

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .op   (in_op),
        .rs1  (in_rs1),
        .rs2  (in_rs2),
        .cond (cond_p0)
    );

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv && !flush && reset_n;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Stage 0 -> 1: direction and target from the raw request
    assign jalr_sum_p0 = in_rs1 + in_imm;
    assign taken_p0    = is_jump(in_op) ? 1'b1 : cond_p0;
    assign target_p0   = is_jalr(in_op) ? (jalr_sum_p0 & ~XLEN'(1)) : (in_pc + in_imm);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            taken_p1       <= 1'b0;
            target_p1      <= '0;
            pc_p1          <= '0;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
            tag_p1         <= '0;
        end else if (in_fire) begin
            taken_p1       <= taken_p0;
            target_p1      <= target_p0;
            pc_p1          <= in_pc;
            pred_taken_p1  <= in_pred_taken;
            pred_target_p1 <= in_pred_target;
            tag_p1         <= in_tag;
        end
    end

    // Stage 1 -> 2: resolve against the prediction; target only matters when taken
    assign link_p1       = pc_p1 + XLEN'(4);
    assign next_pc_p1    = taken_p1 ? target_p1 : link_p1;
    assign mispredict_p1 = (taken_p1 != pred_taken_p1) ||
                           (taken_p1 && (target_p1 != pred_target_p1));
    assign misalign_p1   = taken_p1 && (|target_p1[ALIGN_LSB-1:0]);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_tag        <= '0;
            out_taken      <= 1'b0;
            out_next_pc    <= '0;
            out_link       <= '0;
            out_mispredict <= 1'b0;
            out_misalign   <= 1'b0;
        end else if (s2_adv && vld_p1) begin
            out_tag        <= tag_p1;
            out_taken      <= taken_p1;
            out_next_pc    <= next_pc_p1;
            out_link       <= link_p1;
            out_mispredict <= mispredict_p1;
            out_misalign   <= misalign_p1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    // Counters survive flush; an accepted result counts even in a flush cycle
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else if (out_fire) begin
            perf_resolved <= perf_resolved + 32'd1;
            if (out_mispredict) begin
                perf_mispredict <= perf_mispredict + 32'd1;
            end
        end
    end
`else
    logic unused_fire;
    assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_branch_exec_unit.sv
// Randomized and directed bench for branch_exec_unit with a queue-based reference model.
// Define BRU_PERF_CNT_EN to also check the performance counters.
module tb_branch_exec_unit;

    localparam longint MOD = 64'h1_0000_0000;

    typedef struct packed {
        logic [4:0]  tag;
        logic        taken;
        logic [31:0] next_pc;
        logic [31:0] link;
        logic        mp;
        logic        ma;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_target;
    logic        in_pred_taken;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_tag;
    logic        out_taken;
    logic [31:0] out_next_pc, out_link;
    logic        out_mispredict, out_misalign;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_resolved, perf_mispredict;
    int          m_res, m_mp;
`endif

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    exp_t q[$];

    branch_exec_unit dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_taken(out_taken), .out_next_pc(out_next_pc), .out_link(out_link),
        .out_mispredict(out_mispredict), .out_misalign(out_misalign)
`ifdef BRU_PERF_CNT_EN
        , .perf_resolved(perf_resolved), .perf_mispredict(perf_mispredict)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] pc, rs1, rs2,
                                       imm, input logic pt, input logic [31:0] ptgt,
                                       input logic [4:0] tag);
        exp_t   e;
        longint u1, u2, s1, s2, tgt, lnk;
        bit     tk;
        u1 = longint'(rs1);
        u2 = longint'(rs2);
        s1 = rs1[31] ? u1 - MOD : u1;
        s2 = rs2[31] ? u2 - MOD : u2;
        case (op)
            4'd0:    tk = (u1 == u2);
            4'd1:    tk = (u1 != u2);
            4'd2:    tk = (s1 < s2);
            4'd3:    tk = (s1 >= s2);
            4'd4:    tk = (u1 < u2);
            4'd5:    tk = (u1 >= u2);
            4'd6:    tk = 1'b1;
            4'd7:    tk = 1'b1;
            default: tk = 1'b0;
        endcase
        if (op == 4'd7) begin
            tgt = (u1 + longint'(imm)) % MOD;
            tgt = tgt - (tgt % 2);
        end else begin
            tgt = (longint'(pc) + longint'(imm)) % MOD;
        end
        lnk       = (longint'(pc) + 4) % MOD;
        e.tag     = tag;
        e.taken   = tk;
        e.next_pc = tk ? 32'(tgt) : 32'(lnk);
        e.link    = 32'(lnk);
        e.mp      = (tk != pt) || (tk && (tgt != longint'(ptgt)));
        e.ma      = tk && ((tgt % 4) != 0);
        return e;
    endfunction

    // Scoreboard: ops accepted but not yet emitted, in order
    always @(negedge clock) begin
        exp_t got;
        if (!reset_n) begin
            chk("rst_in_ready", in_ready, 0);
            q.delete();
`ifdef BRU_PERF_CNT_EN
            m_res = 0;
            m_mp  = 0;
`endif
        end else begin
`ifdef BRU_PERF_CNT_EN
            chk("perf_resolved", perf_resolved, m_res);
            chk("perf_mispredict", perf_mispredict, m_mp);
`endif
            chk("in_ready", in_ready, !flush && ((q.size() < 2) || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    got = {out_tag, out_taken, out_next_pc, out_link, out_mispredict, out_misalign};
                    chk("out_data", got, q[0]);
                    if (out_ready) begin
`ifdef BRU_PERF_CNT_EN
                        m_res++;
                        if (q[0].mp) m_mp++;
`endif
                        void'(q.pop_front());
                        popped++;
                    end
                end
            end
            if (flush) q.delete();
            if (in_valid && in_ready)
                q.push_back(ref_model(in_op, in_pc, in_rs1, in_rs2, in_imm,
                                      in_pred_taken, in_pred_target, in_tag));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] pc, rs1, rs2, imm,
                          input logic pt, input logic [31:0] ptgt, input logic [4:0] tag);
        in_op = op; in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_pred_taken = pt; in_pred_target = ptgt; in_tag = tag;
    endtask

    task automatic run1(input string nm, input logic [3:0] op, input logic [31:0] pc, rs1,
                        rs2, imm, input logic pt, input logic [31:0] ptgt, input logic e_tk,
                        input logic [31:0] e_np, e_ln, input logic e_mp, e_ma);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_op(op, pc, rs1, rs2, imm, pt, ptgt, 5'd3);
        step();
        in_valid = 1'b0;
        chk({nm, "_lat1"}, out_valid, 0);
        step();
        chk({nm, "_vld"}, out_valid, 1);
        chk({nm, "_res"}, {out_tag, out_taken, out_next_pc, out_link, out_mispredict, out_misalign},
            {5'd3, e_tk, e_np, e_ln, e_mp, e_ma});
        step();
    endtask

    initial begin
        int   i, c, base;
        bit   fired, saw_stall;
        exp_t e;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0);
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", {out_tag, out_taken, out_next_pc, out_link, out_mispredict, out_misalign}, 0);
        reset_n = 1'b1;
        step();

        run1("beq",  4'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0);
        run1("blt",  4'd2, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 32'h0, 1'b1, 32'h210, 32'h204, 1'b1, 1'b0);
        run1("bltu", 4'd4, 32'h200, 32'hFFFFFFFF, 32'd1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h204, 32'h204, 1'b0, 1'b0);
        run1("bge",  4'd3, 32'h500, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 32'h540, 1'b0, 32'h504, 32'h504, 1'b1, 1'b0);
        run1("bgeu", 4'd5, 32'h500, 32'hFFFFFFFF, 32'd1, 32'h40, 1'b1, 32'h540, 1'b1, 32'h540, 32'h504, 1'b0, 1'b0);
        run1("jalr", 4'd7, 32'h40, 32'h1001, 32'd0, 32'h2, 1'b1, 32'h1002, 1'b1, 32'h1002, 32'h44, 1'b0, 1'b1);
        run1("jal",  4'd6, 32'hFFFFFFFC, 32'd0, 32'd0, 32'h8, 1'b1, 32'h4, 1'b1, 32'h4, 32'h0, 1'b0, 1'b0);
        run1("undef", 4'hB, 32'h300, 32'd1, 32'd1, 32'h8, 1'b1, 32'h308, 1'b0, 32'h304, 32'h304, 1'b1, 1'b0);
        run1("bne_nt", 4'd1, 32'h400, 32'd7, 32'd7, 32'h2, 1'b0, 32'h402, 1'b0, 32'h404, 32'h404, 1'b0, 1'b0);

        // Eight back-to-back ops with the consumer stalled for three cycles
        base = popped; i = 0; c = 0; saw_stall = 1'b0;
        while (i < 8 && c < 50) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = 1'b1;
            set_op(4'($urandom_range(0, 7)), 32'h1000 + 32'(i * 16), $urandom, $urandom, 32'h40,
                   1'b1, 32'h1040 + 32'(i * 16), 5'(i + 8));
            #1;
            fired = in_ready;
            if (!in_ready) saw_stall = 1'b1;
            @(posedge clock);
            #1;
            if (fired) i++;
            c++;
        end
        chk("stall_all_sent", i, 8);
        chk("stall_in_ready_drop", saw_stall, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();
        chk("stall_count", popped - base, 8);

        // Flush with two ops in flight and a new request offered
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(4'd6, 32'h800, 32'd0, 32'd0, 32'h10, 1'b1, 32'h810, 5'd20);
        step();
        set_op(4'd0, 32'h900, 32'd1, 32'd1, 32'h10, 1'b0, 32'h0, 5'd21);
        step();
        flush = 1'b1;
        set_op(4'd6, 32'hA00, 32'd0, 32'd0, 32'h10, 1'b1, 32'hA10, 5'd31);
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid1", out_valid, 0);
        step();
        chk("flush_out_valid2", out_valid, 0);
        step();

        // Reset pulse in the middle of a stream
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_op(4'd7, 32'h40, $urandom, 32'd0, 32'h8, 1'b0, 32'h0, 5'(k + 1));
            step();
        end
        reset_n = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 0);
        step();
        reset_n = 1'b1; in_valid = 1'b0;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_data", {out_tag, out_taken, out_next_pc, out_link, out_mispredict, out_misalign}, 0);
`ifdef BRU_PERF_CNT_EN
        chk("rst_mid_perf", {perf_resolved, perf_mispredict}, 0);
`endif
        step();

        // Randomized traffic with random backpressure and occasional flush
        for (int n = 0; n < 600; n++) begin
            logic [31:0] r1, r2, pc, imm;
            logic [3:0]  op;
            op  = 4'($urandom_range(0, 9));
            pc  = $urandom & 32'hFFFFFFFC;
            r1  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
            r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom;
            e   = ref_model(op, pc, r1, r2, imm, 1'b0, 32'd0, 5'd0);
            set_op(op, pc, r1, r2, imm,
                   ($urandom_range(0, 3) == 0) ? !e.taken : e.taken,
                   ($urandom_range(0, 3) == 0) ? $urandom : e.next_pc, 5'(n));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (8) step();
        chk("drain_empty", q.size(), 0);
        chk("drain_no_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
